// File: rtl/ohm_div_mc.sv
// ohm_div_mc: multi-channel igniter resistance divider.
// Computes R = V*SCALE / (I*1024) with an iterative restoring divider
// that retires RADIX_LOG2 quotient bits per cycle. Results use ADC format
// (6.5 fixed-point ohms, inverted magnitude), and the last result is held
// per channel.
// Build option: define OHM_DIV_AVG_EN to add a per-channel IIR smoother
// (adds one cycle of latency).
//
// state | meaning
// IDLE  | ready; a sample is accepted on valid_in
// LOAD  | form V*SCALE dividend and the I, 2I, 3I multiples
// DIV   | retire RADIX_LOG2 quotient bits per cycle, ITER cycles
// FILT  | apply the per-channel filter (OHM_DIV_AVG_EN builds only)
// OUT   | result strobe cycle
module ohm_div_mc #(
  parameter int CHANNELS   = 2,
  parameter int SCALE      = 42089,
  parameter int I_MIN      = 32,
  parameter int RADIX_LOG2 = 2,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  output logic                   in_ready,
  input  logic [CW-1:0]          ch_in,
  input  logic [11:0]            v_in,
  input  logic [11:0]            i_in,
  output logic                   valid_out,
  output logic [CW-1:0]          ch_out,
  output logic [11:0]            r_out,
  output logic                   lowi_out,
  output logic                   ovf_out,
  output logic [12*CHANNELS-1:0] r_hold
);
  localparam int ITER = 30 / RADIX_LOG2;
  localparam int RW   = 14;
  localparam logic [26:0] SCALE_W = 27'(SCALE);

  typedef enum logic [2:0] {IDLE, LOAD, DIV, FILT, OUT} state_t;
  state_t state;

  logic [CW-1:0] ch_q;
  logic [10:0]   v_q, i_q;
  logic          lowi_q;
  logic [29:0]   num, q, q_nx;
  logic [RW-1:0] rem, rem_sh, rem_nx, m1, m2, m3;
  logic [1:0]    digit;
  logic [4:0]    cnt;
  logic [10:0]   v_mag, i_raw, i_mag;
  logic [21:0]   r_full;
  logic [10:0]   val_c;
  logic          ovf_c;
  logic          ch_ok;
  logic          publish;
  logic [10:0]   pub_val;
  logic          pub_lowi, pub_ovf;

  assign in_ready = (state == IDLE);
  assign ch_ok    = (int'(ch_q) < CHANNELS);

  // Decode ADC-format inputs; negative V clamps to 0, non-positive I to 1
  always_comb begin
    v_mag = v_in[11] ? 11'd0 : (v_in[10:0] ^ 11'h7FF);
    i_raw = i_in[10:0] ^ 11'h7FF;
    i_mag = (i_in[11] || (i_raw == 11'd0)) ? 11'd1 : i_raw;
  end

  // One restoring-divider step: pick the largest multiple of I that fits
  always_comb begin
    rem_sh = (rem << RADIX_LOG2) | RW'(num[29 -: RADIX_LOG2]);
    rem_nx = rem_sh;
    digit  = 2'd0;
    if (RADIX_LOG2 == 2) begin
      if (rem_sh >= m3) begin
        digit  = 2'd3;
        rem_nx = rem_sh - m3;
      end else if (rem_sh >= m2) begin
        digit  = 2'd2;
        rem_nx = rem_sh - m2;
      end else if (rem_sh >= m1) begin
        digit  = 2'd1;
        rem_nx = rem_sh - m1;
      end
    end else if (rem_sh >= m1) begin
      digit  = 2'd1;
      rem_nx = rem_sh - m1;
    end
    q_nx = (q << RADIX_LOG2) | 30'(digit);
  end

  // Final value from the completed quotient: saturate, then low-current override
  always_comb begin
    r_full = 22'(q_nx >> 8);
    ovf_c  = |r_full[21:11];
    val_c  = ovf_c ? 11'h7FF : r_full[10:0];
    if (lowi_q) begin
      val_c = 11'd0;
      ovf_c = 1'b0;
    end
  end

`ifdef OHM_DIV_AVG_EN
  logic [10:0]        val_q;
  logic               lowi_r, ovf_r;
  logic signed [12:0] f_st [CHANNELS];
  logic [CHANNELS-1:0] loaded;
  logic signed [12:0] f_cur, r_s, f_diff, f_new;
  logic               use_filt;

  // Filter arithmetic and choice between filtered and raw value
  always_comb begin
    f_cur    = f_st[ch_q];
    r_s      = $signed({2'b00, val_q});
    f_diff   = r_s - f_cur;
    f_new    = f_cur + (f_diff >>> 2);
    use_filt = ch_ok && !lowi_r && !ovf_r && loaded[ch_q];
    publish  = (state == FILT);
    pub_val  = use_filt ? f_new[10:0] : val_q;
    pub_lowi = lowi_r;
    pub_ovf  = ovf_r;
  end

  // Capture the raw result and update per-channel filter state
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q  <= '0;
      lowi_r <= 1'b0;
      ovf_r  <= 1'b0;
      loaded <= '0;
      for (int k = 0; k < CHANNELS; k++) f_st[k] <= '0;
    end else begin
      if ((state == DIV) && (cnt == 5'd0)) begin
        val_q  <= val_c;
        lowi_r <= lowi_q;
        ovf_r  <= ovf_c;
      end
      if ((state == FILT) && ch_ok) begin
        if (lowi_r || ovf_r) begin
          loaded[ch_q] <= 1'b0;
        end else begin
          f_st[ch_q]   <= use_filt ? f_new : r_s;
          loaded[ch_q] <= 1'b1;
        end
      end
    end
  end
`else
  // Raw result is published directly at the end of the division
  always_comb begin
    publish  = (state == DIV) && (cnt == 5'd0);
    pub_val  = val_c;
    pub_lowi = lowi_q;
    pub_ovf  = ovf_c;
  end
`endif

  // Sequencer, divider datapath and registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid_out <= 1'b0;
      ch_out    <= '0;
      r_out     <= 12'h7FF;
      lowi_out  <= 1'b0;
      ovf_out   <= 1'b0;
      r_hold    <= {CHANNELS{12'h7FF}};
      ch_q      <= '0;
      v_q       <= '0;
      i_q       <= 11'd1;
      lowi_q    <= 1'b0;
      num       <= '0;
      q         <= '0;
      rem       <= '0;
      m1        <= '0;
      m2        <= '0;
      m3        <= '0;
      cnt       <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            ch_q   <= ch_in;
            v_q    <= v_mag;
            i_q    <= i_mag;
            lowi_q <= (int'(i_mag) <= I_MIN);
            state  <= LOAD;
          end
        end
        LOAD: begin
          num   <= {27'(v_q) * SCALE_W, 3'b000};
          rem   <= '0;
          q     <= '0;
          m1    <= RW'(i_q);
          m2    <= RW'(i_q) << 1;
          m3    <= RW'(i_q) + (RW'(i_q) << 1);
          cnt   <= 5'(ITER - 1);
          state <= DIV;
        end
        DIV: begin
          rem <= rem_nx;
          q   <= q_nx;
          num <= num << RADIX_LOG2;
          if (cnt == 5'd0) begin
`ifdef OHM_DIV_AVG_EN
            state <= FILT;
`else
            state <= OUT;
`endif
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        FILT:    state <= OUT;
        OUT:     state <= IDLE;
        default: state <= IDLE;
      endcase
      if (publish) begin
        valid_out <= 1'b1;
        ch_out    <= ch_q;
        r_out     <= {1'b0, pub_val ^ 11'h7FF};
        lowi_out  <= pub_lowi;
        ovf_out   <= pub_ovf;
        if (ch_ok) r_hold[12*int'(ch_q) +: 12] <= {1'b0, pub_val ^ 11'h7FF};
      end
    end
  end

endmodule

// File: tb/tb_ohm_div_mc.sv
// Directed bench for ohm_div_mc, default build (filter disabled), radix 4.
module tb_ohm_div_mc;
  localparam int CW  = 1;
  localparam int LAT = 17;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic          in_ready;
  logic [CW-1:0] ch_in, ch_out;
  logic [11:0]   v_in, i_in, r_out;
  logic          valid_out, lowi_out, ovf_out;
  logic [23:0]   r_hold;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    int         ch;
    logic [11:0] v;
    logic [11:0] i;
    logic [11:0] r;
    logic        lowi;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  ohm_div_mc #(
    .CHANNELS(2), .SCALE(42089), .I_MIN(32), .RADIX_LOG2(2)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .in_ready(in_ready),
    .ch_in(ch_in), .v_in(v_in), .i_in(i_in), .valid_out(valid_out),
    .ch_out(ch_out), .r_out(r_out), .lowi_out(lowi_out), .ovf_out(ovf_out),
    .r_hold(r_hold)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int k, input vec_t t);
    int n;
    @(negedge clk);
    check($sformatf("vec%0d_ready_before", k), 32'(in_ready), 32'd1);
    ch_in = CW'(t.ch); v_in = t.v; i_in = t.i; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    @(negedge clk);
    n = 1;
    check($sformatf("vec%0d_busy", k), 32'(in_ready), 32'd0);
    while (!valid_out && n < 60) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("vec%0d_latency", k), 32'(n), 32'(LAT));
    check($sformatf("vec%0d_r_out", k), 32'(r_out), 32'(t.r));
    check($sformatf("vec%0d_lowi", k), 32'(lowi_out), 32'(t.lowi));
    check($sformatf("vec%0d_ovf", k), 32'(ovf_out), 32'(t.ovf));
    check($sformatf("vec%0d_ch_out", k), 32'(ch_out), 32'(t.ch));
    check($sformatf("vec%0d_r_hold", k), 32'(r_hold[12*t.ch +: 12]), 32'(t.r));
    check($sformatf("vec%0d_busy_out", k), 32'(in_ready), 32'd0);
    @(negedge clk);
    check($sformatf("vec%0d_ready_after", k), 32'(in_ready), 32'd1);
    check($sformatf("vec%0d_strobe_1cyc", k), 32'(valid_out), 32'd0);
    check($sformatf("vec%0d_r_out_hold", k), 32'(r_out), 32'(t.r));
  endtask

  initial begin
    int acc[$];
    int vo[$];
    int nv;

    vecs[0] = '{1, 12'h79B, 12'h732, 12'h57E, 1'b0, 1'b0};
    vecs[1] = '{0, 12'h79B, 12'h7EB, 12'h7FF, 1'b1, 1'b0};
    vecs[2] = '{0, 12'h000, 12'h7DE, 12'h000, 1'b0, 1'b1};
    vecs[3] = '{1, 12'h800, 12'h732, 12'h7FF, 1'b0, 1'b0};
    vecs[4] = '{0, 12'h000, 12'h7DF, 12'h7FF, 1'b1, 1'b0};
    vecs[5] = '{1, 12'h79B, 12'h800, 12'h7FF, 1'b1, 1'b0};
    vecs[6] = '{0, 12'h79B, 12'h7FF, 12'h7FF, 1'b1, 1'b0};
    vecs[7] = '{0, 12'h417, 12'h417, 12'h2DC, 1'b0, 1'b0};
    vecs[8] = '{1, 12'h000, 12'h000, 12'h2DC, 1'b0, 1'b0};
    vecs[9] = '{0, 12'h7FE, 12'h7DE, 12'h7D8, 1'b0, 1'b0};

    reset = 1'b1; valid_in = 1'b0; ch_in = '0; v_in = '0; i_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_ch_out", 32'(ch_out), 32'd0);
    check("rst_r_out", 32'(r_out), 32'h7FF);
    check("rst_lowi", 32'(lowi_out), 32'd0);
    check("rst_ovf", 32'(ovf_out), 32'd0);
    check("rst_r_hold", 32'(r_hold), 32'h7FF7FF);

    for (int k = 0; k < 10; k++) run_vec(k, vecs[k]);
    check("final_r_hold", 32'(r_hold), 32'h2DC7D8);

    // Backpressure: source holds a sample for cycles 0..35
    @(negedge clk);
    ch_in = 1'b1; v_in = 12'h79B; i_in = 12'h732; valid_in = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 36) valid_in = 1'b0;
      if (valid_in && in_ready) acc.push_back(k);
      if (valid_out) vo.push_back(k);
    end
    check("bp_accepts", 32'(acc.size()), 32'd2);
    check("bp_accept0", 32'((acc.size() > 0) ? acc[0] : -1), 32'd0);
    check("bp_accept1", 32'((acc.size() > 1) ? acc[1] : -1), 32'd18);
    check("bp_strobes", 32'(vo.size()), 32'd2);
    check("bp_strobe0", 32'((vo.size() > 0) ? vo[0] : -1), 32'd17);
    check("bp_strobe1", 32'((vo.size() > 1) ? vo[1] : -1), 32'd35);
    check("bp_r_out", 32'(r_out), 32'h57E);

    // Reset at cycle 8 of a division
    @(negedge clk);
    ch_in = 1'b0; v_in = 12'h417; i_in = 12'h417; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    nv = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (valid_out) nv++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 30; k++) begin
      if (valid_out) nv++;
      @(negedge clk);
    end
    check("mid_rst_no_strobe", 32'(nv), 32'd0);
    check("mid_rst_r_hold", 32'(r_hold), 32'h7FF7FF);
    check("mid_rst_r_out", 32'(r_out), 32'h7FF);
    check("mid_rst_ovf", 32'(ovf_out), 32'd0);

    run_vec(10, vecs[0]);
    check("post_rst_r_hold", 32'(r_hold), 32'h57E7FF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
